multiples_checker: RTL and testbench
====================================

# multiples_checker

Bit-serial divisibility checker, parametrised successor to the 5-bit combinational multiples detector. It accepts a WIDTH-bit unsigned operand on a start strobe and consumes it MSB-first, one bit per clock. It maintains one running residue per divisor 2..MAXDIV, and after WIDTH cycles it presents a registered divisibility flag vector plus a masked "all selected" flag. It sits in the lab datapath between the switch/operand register and the display/LED logic, and replaces hard-coded divisor lists with a parameter.

## Interface
- WIDTH, 8: operand width in bits; legal range 1..32.
- MAXDIV, 7: largest divisor checked; divisors 2..MAXDIV; legal range 2..15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- num  in  WIDTH  operand; captured on accepted start.
- mask  in  MAXDIV-1  divisor select for mul_all; bit i-2 selects divisor i; captured with num.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; flags valid from this cycle.
- mul  out  MAXDIV-1  bit i-2 = 1 iff num mod i == 0.
- mul_all  out  1  AND of mul bits selected by captured mask; 0 if mask == 0.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE with start=1: capture num into the shift register and mask into mask_q, clear all residues, set bit counter to WIDTH-1, go to SHIFT.
- SHIFT: each edge takes the MSB b of the shift register and updates every residue r_d as follows: t = 2*r_d + b; r_d' = t - d if t >= d, else t. A single conditional subtract suffices because t <= 2d-1. The register then shifts left and the counter decrements.
- When SHIFT runs with counter == 0: compute final residues and register mul[d-2] = (r_d' == 0) for all d. Register mul_all from the mask. Pulse done and return to IDLE.
- Residue width is clog2(MAXDIV+1). Operand is unsigned. num = 0 yields all mul bits = 1.
- start while busy=1 is ignored. num and mask changes during SHIFT have no effect.
- mul and mul_all hold their values until the next completion. They do not change on a new start.
- Reset, including mid-SHIFT: state IDLE, busy=0, done=0, mul=0, mul_all=0, residues, counter and shift register = 0. No done pulse is produced for the aborted operand.

## Timing
- Start accepted at edge E0. Then busy=1 from after E0 through the cycle before done.
- Edges E1..E_WIDTH process bits WIDTH-1..0.
- After E_WIDTH: done=1 for exactly one cycle, busy=0, and flags are valid.
- Latency from start edge to done is WIDTH+1 cycles. Throughput is one operand per WIDTH+1 cycles.
- Back-to-back: start=1 during the done cycle is accepted at the next edge. done and the new busy never overlap.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package multiples_pkg holds the state enum (IDLE, SHIFT) and a residue-width constant function resw(maxdiv) = clog2(maxdiv+1).
- Sub-module residue_lane, parameter DIV: inputs clk, rst, clr, en, bit; output zero. Instantiate it in a generate loop for DIV = 2..MAXDIV.
- The top level holds the FSM, bit counter, shift register, mask_q and output registers.

## Test plan
With WIDTH=8 and MAXDIV=7, mul bit order is divisors 2,3,4,5,6,7:
- num=30, mask={2,3,5}, start -> done 9 cycles after the start edge; mul 2..7 = 1,1,0,1,1,0; mul_all=1.
- num=0, mask=all -> mul all 1; mul_all=1.
- num=255, mask={3,5} -> mul 2..7 = 0,1,0,1,0,0; mul_all=1. Repeat with mask={2,3} -> mul_all=0.
- num=84 start, then start with num=35 at cycle 3 -> second start ignored; result mul 2..7 = 1,1,1,0,1,1. Then start on the done cycle with num=35 -> accepted; result 0,0,0,1,0,1.
- rst asserted during SHIFT at cycle 4 -> next cycle busy=0, mul=0, mul_all=0; no done pulse within 20 cycles.
- mask=0, num=60 -> mul 2..7 = 1,1,1,1,1,0; mul_all=0.

Source files
------------

// File: rtl/multiples_pkg.sv
// Shared types and helpers for the bit-serial divisibility checker.
package multiples_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    // Bits needed to hold any residue modulo a divisor up to maxdiv.
    function automatic int unsigned resw(input int unsigned maxdiv);
        return $clog2(maxdiv + 1);
    endfunction

endpackage

// File: rtl/residue_lane.sv
// Running residue modulo DIV of an MSB-first bit stream.
// zero reports whether the residue after the current bit would be zero.
module residue_lane
    import multiples_pkg::*;
#(
    parameter int unsigned DIV = 3,
    parameter int unsigned RW  = resw(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic sbit,
    output logic zero
);

    localparam logic [RW:0] DivT = (RW + 1)'(DIV);

    logic [RW-1:0] r_q;
    logic [RW-1:0] r_next;
    logic [RW:0]   t;
    logic [RW:0]   t_sub;

    // t = 2r + b never reaches 2*DIV, so one conditional subtract is enough.
    always_comb begin
        t      = {r_q, sbit};
        t_sub  = t - DivT;
        r_next = (t >= DivT) ? t_sub[RW-1:0] : t[RW-1:0];
    end

    assign zero = (r_next == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_next;
        end
    end

endmodule

// File: rtl/multiples_checker.sv
// Bit-serial divisibility checker: consumes a WIDTH-bit operand MSB-first and
// flags divisibility by every divisor 2..MAXDIV after WIDTH shift cycles.
module multiples_checker
    import multiples_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned MAXDIV = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  num,
    input  logic [MAXDIV-2:0] mask,
    output logic              busy,
    output logic              done,
    output logic [MAXDIV-2:0] mul,
    output logic              mul_all
);

    localparam int unsigned RW = resw(MAXDIV);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sr_q;
    logic [CW-1:0]     cnt_q;
    logic [MAXDIV-2:0] mask_q;
    logic [MAXDIV-2:0] mul_q;
    logic              mul_all_q;
    logic              done_q;
    logic              load, step, fin;
    logic [MAXDIV-2:0] zero;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            mul_q     <= '0;
            mul_all_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= fin;
            if (load) begin
                sr_q   <= num;
                mask_q <= mask;
                cnt_q  <= CW'(WIDTH - 1);
            end else if (step) begin
                sr_q  <= sr_q << 1;
                cnt_q <= fin ? '0 : cnt_q - CW'(1);
            end
            // Flags only move on completion; a new start leaves them intact.
            if (fin) begin
                mul_q     <= zero;
                mul_all_q <= (mask_q != '0) && ((zero & mask_q) == mask_q);
            end
        end
    end

    for (genvar d = 2; d <= MAXDIV; d++) begin : g_lane
        residue_lane #(
            .DIV(d),
            .RW (RW)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (load),
            .en  (step),
            .sbit(sr_q[WIDTH-1]),
            .zero(zero[d-2])
        );
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign mul     = mul_q;
    assign mul_all = mul_all_q;

endmodule

// File: tb/tb_multiples_checker.sv
// Directed bench for multiples_checker with WIDTH=8, MAXDIV=7 (mul bit 0 = divisor 2).
module tb_multiples_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num;
    logic [5:0] mask;
    logic       busy, done, mul_all;
    logic [5:0] mul;

    int checks = 0;
    int errors = 0;

    multiples_checker #(
        .WIDTH (8),
        .MAXDIV(7)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .num    (num),
        .mask   (mask),
        .busy   (busy),
        .done   (done),
        .mul    (mul),
        .mul_all(mul_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] num;
        logic [5:0] mask;
        logic [5:0] mul;
        logic       all;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive start before edge E0; returns at the sample just after E0.
    task automatic launch(input logic [7:0] n, input logic [5:0] m);
        num   = n;
        mask  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts samples from the launch sample (index 0) until done is seen.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 30 cycles");
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{"n30",       8'd30,  6'b001011, 6'b011011, 1'b1};
        vecs[1] = '{"n0",        8'd0,   6'b111111, 6'b111111, 1'b1};
        vecs[2] = '{"n255_m35",  8'd255, 6'b001010, 6'b001010, 1'b1};
        vecs[3] = '{"n255_m23",  8'd255, 6'b000011, 6'b001010, 1'b0};
        vecs[4] = '{"n60_m0",    8'd60,  6'b000000, 6'b011111, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        num   = '0;
        mask  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mul", 32'(mul), 0);
        check("rst_mul_all", 32'(mul_all), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            launch(vecs[i].num, vecs[i].mask);
            check({vecs[i].name, "_busy"}, 32'(busy), 1);
            wait_done(1, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 9);
            check({vecs[i].name, "_mul"}, 32'(mul), 32'(vecs[i].mul));
            check({vecs[i].name, "_mul_all"}, 32'(mul_all), 32'(vecs[i].all));
            check({vecs[i].name, "_busy_at_done"}, 32'(busy), 0);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 32'(done), 0);
        end

        // Start during SHIFT is ignored; flags hold across the new start.
        launch(8'd84, 6'b111111);
        check("hold_mul", 32'(mul), 32'(6'b011111));
        @(negedge clk);
        num   = 8'd35;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        check("ignore_latency", 32'(lat), 9);
        check("n84_mul", 32'(mul), 32'(6'b110111));
        check("n84_mul_all", 32'(mul_all), 0);

        // Back-to-back start on the done cycle.
        launch(8'd35, 6'b101000);
        check("b2b_done_low", 32'(done), 0);
        check("b2b_busy", 32'(busy), 1);
        wait_done(1, lat);
        check("b2b_latency", 32'(lat), 9);
        check("n35_mul", 32'(mul), 32'(6'b101000));
        check("n35_mul_all", 32'(mul_all), 1);
        @(negedge clk);

        // Reset mid-SHIFT aborts with no done pulse.
        launch(8'd84, 6'b111111);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_mul", 32'(mul), 0);
        check("abort_mul_all", 32'(mul_all), 0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) lat++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(lat), 0);
        check("abort_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
